// File: rtl/timer_pkg.sv
// timer_pkg: register offsets, AXI response codes, FSM states and byte-strobe merge for machine_timer
package timer_pkg;
  localparam logic [2:0] MTIME_LO    = 3'd0;
  localparam logic [2:0] MTIME_HI    = 3'd1;
  localparam logic [2:0] MTIMECMP_LO = 3'd2;
  localparam logic [2:0] MTIMECMP_HI = 3'd3;
  localparam logic [2:0] MSIP        = 3'd4;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  typedef enum logic {W_IDLE = 1'b0, W_RESP = 1'b1} w_state_t;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} r_state_t;
  function automatic logic [31:0] apply_strb(input logic [31:0] old, input logic [31:0] data,
                                             input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) r[8*i+:8] = strb[i] ? data[8*i+:8] : old[8*i+:8];
    return r;
  endfunction
endpackage

// File: rtl/axi_lite_reg_if.sv
// axi_lite_reg_if: AXI4-Lite write/read handshake FSMs in front of a small register file
//   AXI side : aw*/w*/b*/ar*/r* slave channels, address bits [4:2] select a register
//   reg side : wr_en/wr_addr/wr_data/wr_strb out, rd_en/rd_addr out, rd_data/rd_err in
module axi_lite_reg_if
  import timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [2:0]            axi_awprot,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [31:0]           axi_wdata,
  input  logic [3:0]            axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [2:0]            axi_arprot,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [31:0]           axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  wr_en,
  output logic [2:0]            wr_addr,
  output logic [31:0]           wr_data,
  output logic [3:0]            wr_strb,
  output logic                  rd_en,
  output logic [2:0]            rd_addr,
  input  logic [31:0]           rd_data,
  input  logic                  rd_err
);
  w_state_t w_state;
  r_state_t r_state;
  logic     unused_bits;
  // AW and W are only accepted together, so a single strobe covers both channels
  assign wr_en       = !reset && w_state == W_IDLE && axi_awvalid && axi_wvalid;
  assign axi_awready = wr_en;
  assign axi_wready  = wr_en;
  assign axi_bvalid  = w_state == W_RESP;
  assign axi_arready = !reset && r_state == R_IDLE;
  assign axi_rvalid  = r_state == R_DATA;
  assign rd_en       = axi_arready && axi_arvalid;
  assign wr_addr     = axi_awaddr[4:2];
  assign wr_data     = axi_wdata;
  assign wr_strb     = axi_wstrb;
  assign rd_addr     = axi_araddr[4:2];
  assign unused_bits = ^{axi_awaddr, axi_araddr, axi_awprot, axi_arprot};
  always_ff @(posedge clk) begin
    if (reset) begin
      w_state   <= W_IDLE;
      r_state   <= R_IDLE;
      axi_bresp <= RESP_OKAY;
      axi_rdata <= '0;
      axi_rresp <= RESP_OKAY;
    end else begin
      if (wr_en) begin
        w_state   <= W_RESP;
        axi_bresp <= wr_addr > MSIP ? RESP_SLVERR : RESP_OKAY;
      end else if (axi_bvalid && axi_bready) w_state <= W_IDLE;
      if (rd_en) begin
        r_state   <= R_DATA;
        axi_rdata <= rd_data;
        axi_rresp <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end else if (axi_rvalid && axi_rready) r_state <= R_IDLE;
    end
  end
endmodule

// File: rtl/machine_timer.sv
// machine_timer: RISC-V mtime/mtimecmp/msip timer unit on an AXI4-Lite slave port
//   clk/reset     : rising-edge clock, synchronous active-high reset
//   axi_*         : AXI4-Lite slave (0x00/04 mtime, 0x08/0C mtimecmp, 0x10 msip, 0x14-0x1C SLVERR)
//   int_req_timer : registered mtime >= mtimecmp
//   int_req_soft  : msip[0]
//   TIMER_PRESCALER_EN : when defined, mtime ticks once every PRESCALE cycles instead of every cycle
module machine_timer
  import timer_pkg::*;
#(
  parameter int ADDR_WIDTH = 5,
  parameter int PRESCALE   = 100
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] axi_awaddr,
  input  logic [2:0]            axi_awprot,
  input  logic                  axi_awvalid,
  output logic                  axi_awready,
  input  logic [31:0]           axi_wdata,
  input  logic [3:0]            axi_wstrb,
  input  logic                  axi_wvalid,
  output logic                  axi_wready,
  output logic [1:0]            axi_bresp,
  output logic                  axi_bvalid,
  input  logic                  axi_bready,
  input  logic [ADDR_WIDTH-1:0] axi_araddr,
  input  logic [2:0]            axi_arprot,
  input  logic                  axi_arvalid,
  output logic                  axi_arready,
  output logic [31:0]           axi_rdata,
  output logic [1:0]            axi_rresp,
  output logic                  axi_rvalid,
  input  logic                  axi_rready,
  output logic                  int_req_timer,
  output logic                  int_req_soft
);
  logic        wr_en, rd_en, rd_err, msip, tick, mtime_wr;
  logic [2:0]  wr_addr, rd_addr;
  logic [31:0] wr_data, rd_data;
  logic [3:0]  wr_strb;
  logic [63:0] mtime, mtimecmp, mtime_nxt, mtimecmp_nxt;
  axi_lite_reg_if #(.ADDR_WIDTH(ADDR_WIDTH)) u_if (
    .clk(clk), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_err(rd_err)
  );
  assign mtime_wr = wr_en && (wr_addr == MTIME_LO || wr_addr == MTIME_HI);
`ifdef TIMER_PRESCALER_EN
  logic [31:0] presc;
  assign tick = presc == 32'(PRESCALE - 1);
  // a write to mtime restarts the prescale period so the new value lasts a full PRESCALE cycles
  always_ff @(posedge clk) begin
    if (reset || mtime_wr || tick) presc <= '0;
    else presc <= presc + 32'd1;
  end
`else
  logic [31:0] unused_prescale;
  assign unused_prescale = 32'(PRESCALE);
  assign tick = 1'b1;
`endif
  // software writes to mtime suppress that cycle's increment
  always_comb begin
    mtime_nxt = wr_en && wr_addr == MTIME_LO ? {mtime[63:32], apply_strb(mtime[31:0], wr_data, wr_strb)}
              : wr_en && wr_addr == MTIME_HI ? {apply_strb(mtime[63:32], wr_data, wr_strb), mtime[31:0]}
              : mtime + 64'(tick);
    mtimecmp_nxt = wr_en && wr_addr == MTIMECMP_LO ? {mtimecmp[63:32], apply_strb(mtimecmp[31:0], wr_data, wr_strb)}
                 : wr_en && wr_addr == MTIMECMP_HI ? {apply_strb(mtimecmp[63:32], wr_data, wr_strb), mtimecmp[31:0]}
                 : mtimecmp;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime         <= '0;
      mtimecmp      <= '1;
      msip          <= 1'b0;
      int_req_timer <= 1'b0;
    end else begin
      mtime         <= mtime_nxt;
      mtimecmp      <= mtimecmp_nxt;
      int_req_timer <= mtime_nxt >= mtimecmp_nxt;
      if (wr_en && wr_addr == MSIP && wr_strb[0]) msip <= wr_data[0];
    end
  end
  assign int_req_soft = msip;
  assign rd_err  = rd_addr > MSIP;
  // reads see register contents before any same-cycle write lands
  assign rd_data = !rd_en ? '0
                 : rd_addr == MTIME_LO    ? mtime[31:0]
                 : rd_addr == MTIME_HI    ? mtime[63:32]
                 : rd_addr == MTIMECMP_LO ? mtimecmp[31:0]
                 : rd_addr == MTIMECMP_HI ? mtimecmp[63:32]
                 : rd_addr == MSIP        ? {31'd0, msip}
                 : '0;
endmodule

// File: tb/tb_machine_timer.sv
// tb_machine_timer: scoreboard bench for machine_timer against a time-based reference model
module tb_machine_timer;
`ifdef TIMER_PRESCALER_EN
  localparam int PS  = 4;
  localparam int PRE = 4;
`else
  localparam int PS  = 1;
  localparam int PRE = 100;
`endif
  logic        clk = 0, reset = 1;
  logic [4:0]  axi_awaddr = 0, axi_araddr = 0;
  logic [2:0]  axi_awprot = 0, axi_arprot = 0;
  logic        axi_awvalid = 0, axi_wvalid = 0, axi_bready = 0, axi_arvalid = 0, axi_rready = 0;
  logic [31:0] axi_wdata = 0;
  logic [3:0]  axi_wstrb = 0;
  logic        axi_awready, axi_wready, axi_bvalid, axi_arready, axi_rvalid;
  logic [1:0]  axi_bresp, axi_rresp;
  logic [31:0] axi_rdata;
  logic        int_req_timer, int_req_soft;

  machine_timer #(.ADDR_WIDTH(5), .PRESCALE(PRE)) dut (
    .clk(clk), .reset(reset),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .int_req_timer(int_req_timer), .int_req_soft(int_req_soft)
  );

  always #5 clk = ~clk;
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // reference model: mtime after edge e = m_base + (e - m_e0) / PS
  logic [63:0] m_base = 0, m_cmp = '1;
  longint      m_e0 = 0;
  logic        m_msip = 0;
  bit          chk_en = 0, hold = 0;
  logic [33:0] rq[$];
  logic [1:0]  bq[$];
  int          n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [63:0] mt(input longint e);
    return m_base + 64'((e - m_e0) / PS);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[8*i+:8] = d[8*i+:8];
    return r;
  endfunction

  function automatic logic [33:0] exp_rd(input logic [2:0] a, input longint e);
    logic [63:0] t;
    t = mt(e);
    case (a)
      3'd0:    return {2'b00, t[31:0]};
      3'd1:    return {2'b00, t[63:32]};
      3'd2:    return {2'b00, m_cmp[31:0]};
      3'd3:    return {2'b00, m_cmp[63:32]};
      3'd4:    return {2'b00, 31'd0, m_msip};
      default: return {2'b10, 32'd0};
    endcase
  endfunction

  task automatic model_wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s, input longint e);
    logic [63:0] t;
    t = mt(e - 1);
    case (a)
      3'd0: begin m_base = {t[63:32], merge(t[31:0], d, s)}; m_e0 = e; end
      3'd1: begin m_base = {merge(t[63:32], d, s), t[31:0]}; m_e0 = e; end
      3'd2: m_cmp[31:0]  = merge(m_cmp[31:0], d, s);
      3'd3: m_cmp[63:32] = merge(m_cmp[63:32], d, s);
      3'd4: if (s[0]) m_msip = d[0];
      default: ;
    endcase
    bq.push_back(a > 3'd4 ? 2'b10 : 2'b00);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((axi_bvalid || axi_rvalid) && n < 200) begin @(negedge clk); n++; end
    if (n >= 200) chk("idle_timeout", 64'(axi_bvalid || axi_rvalid), 64'd0);
  endtask

  task automatic xact(input bit dw, input logic [2:0] wa, input logic [31:0] wd, input logic [3:0] ws,
                      input bit dr, input logic [2:0] ra);
    int n = 0;
    bit wp = dw, rp = dr, wh, rh;
    wait_idle();
    axi_awaddr = {wa, 2'($urandom)}; axi_wdata = wd; axi_wstrb = ws;
    axi_araddr = {ra, 2'($urandom)}; axi_awvalid = dw; axi_wvalid = dw; axi_arvalid = dr;
    while ((wp || rp) && n < 100) begin
      #1;
      wh = wp && axi_awready && axi_wready;
      rh = rp && axi_arready;
      @(posedge clk); #1;
      if (rh) begin rq.push_back(exp_rd(ra, cyc - 1)); axi_arvalid = 0; rp = 0; end
      if (wh) begin model_wr(wa, wd, ws, cyc); axi_awvalid = 0; axi_wvalid = 0; wp = 0; end
      n++;
    end
    if (wp || rp) begin
      chk("handshake_timeout", {wp, rp}, 64'd0);
      axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0;
    end
  endtask

  initial forever begin
    @(negedge clk);
    axi_bready = hold ? 1'b0 : ($urandom % 3 != 0);
    axi_rready = hold ? 1'b0 : ($urandom % 3 != 0);
  end

  // monitor: pops the scoreboard whenever a response handshake is about to complete
  initial begin
    logic [33:0] e;
    forever begin
      @(negedge clk); #2;
      if (chk_en) begin
        if (axi_rvalid && axi_rready) begin
          if (rq.size() == 0) chk("rd_unexpected", 64'd1, 64'd0);
          else begin
            e = rq.pop_front();
            chk("rdata", axi_rdata, e[31:0]);
            chk("rresp", axi_rresp, e[33:32]);
          end
        end
        if (axi_bvalid && axi_bready) begin
          if (bq.size() == 0) chk("wr_unexpected", 64'd1, 64'd0);
          else chk("bresp", axi_bresp, bq.pop_front());
        end
        chk("int_timer", int_req_timer, 64'(mt(cyc) >= m_cmp));
        chk("int_soft", int_req_soft, m_msip);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, tests %0d failed %0d", n_tests, n_fail);
    $fatal(1);
  end

  initial begin
    logic [31:0] rd0;
    bit dw, dr;
    logic [2:0] a;
    logic [31:0] d;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_awready", axi_awready, 0); chk("rst_wready", axi_wready, 0);
    chk("rst_arready", axi_arready, 0); chk("rst_bvalid", axi_bvalid, 0);
    chk("rst_rvalid", axi_rvalid, 0);   chk("rst_bresp", axi_bresp, 0);
    chk("rst_rresp", axi_rresp, 0);     chk("rst_timer", int_req_timer, 0);
    chk("rst_soft", int_req_soft, 0);
    reset = 0; m_e0 = cyc; chk_en = 1;
    repeat (10) @(posedge clk);
    xact(0, 0, 0, 0, 1, 3'd0);
    xact(1, 3'd0, 0, 4'hf, 0, 0);
    xact(1, 3'd1, 0, 4'hf, 0, 0);
    xact(1, 3'd3, 0, 4'hf, 0, 0);
    xact(1, 3'd2, 20, 4'hf, 0, 0);
    repeat (30 * PS) @(posedge clk);
    @(negedge clk); #3 chk("timer_rise", int_req_timer, 1);
    xact(1, 3'd2, 32'hFFFF_FFFF, 4'hf, 0, 0);
    @(negedge clk); #3 chk("timer_fall", int_req_timer, 0);
    xact(1, 3'd0, 32'hFFFF_FFFE, 4'hf, 0, 0);
    xact(1, 3'd1, 0, 4'hf, 0, 0);
    repeat (3 * PS) @(posedge clk);
    xact(0, 0, 0, 0, 1, 3'd1);
    xact(0, 0, 0, 0, 1, 3'd0);
    xact(1, 3'd4, 32'hFFFF_FFFF, 4'hf, 1, 3'd4);
    xact(0, 0, 0, 0, 1, 3'd4);
    xact(1, 3'd4, 0, 4'hf, 0, 0);
    @(negedge clk); #3 chk("soft_fall", int_req_soft, 0);
    xact(1, 3'd2, 32'h0000_AB00, 4'b0010, 0, 0);
    xact(0, 0, 0, 0, 1, 3'd2);
    xact(0, 0, 0, 0, 1, 3'd3);
    xact(1, 3'd2, 32'h1234_5678, 4'hf, 1, 3'd2);
    xact(1, 3'd0, 32'h0000_0100, 4'hf, 1, 3'd0);
    xact(1, 3'd0, 0, 4'hf, 0, 0);
    xact(1, 3'd1, 0, 4'hf, 0, 0);
    repeat (40) @(posedge clk);
    xact(0, 0, 0, 0, 1, 3'd0);
    wait_idle();
    axi_awvalid = 1; #1 chk("aw_only_ready", axi_awready, 0);
    @(negedge clk); axi_awvalid = 0; axi_wvalid = 1; #1 chk("w_only_ready", axi_wready, 0);
    @(negedge clk); axi_wvalid = 0;
    wait_idle();
    hold = 1;
    @(negedge clk);
    xact(1, 3'd4, 1, 4'hf, 1, 3'd6);
    @(negedge clk); #3;
    rd0 = axi_rdata;
    chk("unmapped_rdata", axi_rdata, 0); chk("unmapped_rresp", axi_rresp, 2'b10);
    axi_awaddr = 0; axi_wdata = 32'h55; axi_wstrb = 4'hf; axi_araddr = 0;
    axi_awvalid = 1; axi_wvalid = 1; axi_arvalid = 1;
    repeat (5) begin
      #1;
      chk("hold_bvalid", axi_bvalid, 1); chk("hold_rvalid", axi_rvalid, 1);
      chk("hold_rdata", axi_rdata, rd0); chk("hold_awready", axi_awready, 0);
      chk("hold_arready", axi_arready, 0);
      @(negedge clk); #3;
    end
    axi_awvalid = 0; axi_wvalid = 0; axi_arvalid = 0; hold = 0;
    repeat (150) begin
      dw = $urandom % 2; dr = $urandom % 2;
      if (!dw && !dr) dr = 1;
      a = 3'($urandom);
      d = ($urandom % 3 == 0) ? ($urandom % 64) : (($urandom % 4 == 0) ? 32'hFFFF_FFF0 : $urandom);
      xact(dw, a, d, 4'($urandom), dr, ($urandom % 2 == 0) ? a : 3'($urandom));
    end
    wait_idle();
    hold = 1;
    @(negedge clk);
    xact(1, 3'd2, 5, 4'hf, 0, 0);
    chk_en = 0; reset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("midrst_bvalid", axi_bvalid, 0);
    reset = 0; hold = 0;
    rq.delete(); bq.delete();
    m_base = 0; m_e0 = cyc; m_cmp = '1; m_msip = 0; chk_en = 1;
    xact(0, 0, 0, 0, 1, 3'd2);
    xact(0, 0, 0, 0, 1, 3'd0);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("rq_drained", rq.size(), 0);
    chk("bq_drained", bq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
